// File: rtl/coin_tracker.sv
// ---------------------------------------------------------------------------
// coin_tracker
//
// Purpose:
//   Holds the per-tile coin occupancy map for the 48x27 playfield. After a
//   start pulse, or a level restart, it scans the map ROM and marks every
//   tile whose code means "coin". During play it clears the coin under
//   Pacman's centre tile and updates the coins-remaining count and the
//   score. It also returns a registered coin lookup for the pixel being
//   drawn, and flags level clear once every coin has been eaten.
//
// Ports:
//   clk_pix        in   pixel clock; all logic runs on its rising edge
//   rstn           in   asynchronous active-low reset
//   start          in   1-cycle pulse; starts the first scan from IDLE
//   game_reset     in   level restart; rescans from address 0 (not in IDLE)
//   rom_addr       out  map ROM read address
//   rom_code       in   map ROM data, valid one cycle after rom_addr
//   pac_valid      in   pac_tile_addr is valid this cycle
//   pac_tile_addr  in   tile under Pacman's centre
//   pix_tile_addr  in   tile under the current pixel
//   pix_coin       out  coin present at pix_tile_addr (1-cycle latency)
//   coins_left     out  coins remaining on the level
//   score          out  accumulated score, saturating
//   eat_pulse      out  1-cycle pulse per coin eaten
//   init_done      out  high in RUN and CLEAR
//   level_clear    out  high in CLEAR
// ---------------------------------------------------------------------------
module coin_tracker #(
  parameter int MAP_W     = 48,
  parameter int MAP_H     = 27,
  parameter int ADDR_W    = 11,
  parameter int COIN_CODE = 2,
  parameter int SCORE_W   = 16,
  parameter int POINTS    = 10
) (
  input  logic               clk_pix,
  input  logic               rstn,
  input  logic               start,
  input  logic               game_reset,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [3:0]         rom_code,
  input  logic               pac_valid,
  input  logic [ADDR_W-1:0]  pac_tile_addr,
  input  logic [ADDR_W-1:0]  pix_tile_addr,
  output logic               pix_coin,
  output logic [ADDR_W-1:0]  coins_left,
  output logic [SCORE_W-1:0] score,
  output logic               eat_pulse,
  output logic               init_done,
  output logic               level_clear
);

  localparam int N = MAP_W * MAP_H;

  // Address-width copies of the map bounds, so the comparisons below
  // stay within the tile address width.
  localparam logic [ADDR_W-1:0]  N_A      = ADDR_W'(N);
  localparam logic [ADDR_W-1:0]  LAST_A   = ADDR_W'(N - 1);
  localparam logic [ADDR_W-1:0]  ONE_A    = ADDR_W'(1);
  localparam logic [3:0]         COIN_C   = 4'(COIN_CODE);
  localparam logic [SCORE_W:0]   POINTS_S = (SCORE_W + 1)'(POINTS);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    RUN,
    CLEAR
  } state_e;

  state_e             state_q, state_d;
  logic [N-1:0]       map_q, map_d;
  logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
  logic               issue_q, issue_d;
  logic               wr_vld_q, wr_vld_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0]  coins_q, coins_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               pix_coin_q, pix_coin_d;
  logic               eat_q, eat_d;
  logic               init_done_q, init_done_d;
  logic               level_clear_q, level_clear_d;

  logic               begin_scan;
  logic               eat_hit;
  logic               is_coin;
  logic [SCORE_W:0]   score_sum;

  // One extra bit of headroom lets the adder carry show saturation.
  assign score_sum = {1'b0, score_q} + POINTS_S;

  // Next-state logic for the FSM, the ROM scan pipeline, the coin map and
  // the counters.
  //
  // The ROM answers one cycle after it sees an address, so the scan sends
  // addresses from rom_addr_q (while issue_q is set) and writes the map one
  // cycle later, using the delayed wr_addr_q/wr_vld_q pair. The scan ends
  // after the write of the last entry. That write's own count decides
  // between RUN and CLEAR.
  //
  // A restart (start from IDLE, or game_reset in any other state) is handled
  // in one place after the case statement. That path overrides anything the
  // current state decided, which is how an eat in the same cycle as
  // game_reset gets dropped.
  always_comb begin
    state_d       = state_q;
    map_d         = map_q;
    rom_addr_d    = rom_addr_q;
    issue_d       = issue_q;
    wr_vld_d      = 1'b0;
    wr_addr_d     = wr_addr_q;
    coins_d       = coins_q;
    score_d       = score_q;
    eat_d         = 1'b0;
    begin_scan    = 1'b0;
    is_coin       = (rom_code == COIN_C);
    eat_hit       = pac_valid && (pac_tile_addr < N_A) && map_q[pac_tile_addr];

    case (state_q)
      IDLE: begin
        if (start) begin
          begin_scan = 1'b1;
        end
      end

      SCAN: begin
        if (game_reset) begin
          begin_scan = 1'b1;
        end else begin
          wr_vld_d  = issue_q;
          wr_addr_d = rom_addr_q;
          if (issue_q) begin
            if (rom_addr_q == LAST_A) begin
              issue_d = 1'b0;
            end else begin
              rom_addr_d = rom_addr_q + ONE_A;
            end
          end
          if (wr_vld_q) begin
            if (wr_addr_q < N_A) begin
              map_d[wr_addr_q] = is_coin;
            end
            coins_d = coins_q + ADDR_W'(is_coin);
            if (wr_addr_q == LAST_A) begin
              state_d = (coins_d != '0) ? RUN : CLEAR;
            end
          end
        end
      end

      RUN: begin
        if (game_reset) begin
          begin_scan = 1'b1;
        end else if (eat_hit) begin
          map_d[pac_tile_addr] = 1'b0;
          coins_d              = coins_q - ONE_A;
          score_d              = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
          eat_d                = 1'b1;
          if (coins_q == ONE_A) begin
            state_d = CLEAR;
          end
        end
      end

      CLEAR: begin
        if (game_reset) begin
          begin_scan = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // The map is not cleared here. The scan overwrites every entry.
    if (begin_scan) begin
      state_d    = SCAN;
      rom_addr_d = '0;
      issue_d    = 1'b1;
      wr_vld_d   = 1'b0;
      coins_d    = '0;
    end

    init_done_d   = (state_d == RUN) || (state_d == CLEAR);
    level_clear_d = (state_d == CLEAR);

    // The pixel lookup reads the map before this cycle's eat is applied.
    // It is also masked by game_reset, so the first scan cycle already
    // reads zero.
    pix_coin_d = ((state_q == RUN) || (state_q == CLEAR)) && !game_reset &&
                 (pix_tile_addr < N_A) && map_q[pix_tile_addr];
  end

  // State and output registers. Reset returns to IDLE with an empty map.
  always_ff @(posedge clk_pix or negedge rstn) begin
    if (!rstn) begin
      state_q       <= IDLE;
      map_q         <= '0;
      rom_addr_q    <= '0;
      issue_q       <= 1'b0;
      wr_vld_q      <= 1'b0;
      wr_addr_q     <= '0;
      coins_q       <= '0;
      score_q       <= '0;
      pix_coin_q    <= 1'b0;
      eat_q         <= 1'b0;
      init_done_q   <= 1'b0;
      level_clear_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      map_q         <= map_d;
      rom_addr_q    <= rom_addr_d;
      issue_q       <= issue_d;
      wr_vld_q      <= wr_vld_d;
      wr_addr_q     <= wr_addr_d;
      coins_q       <= coins_d;
      score_q       <= score_d;
      pix_coin_q    <= pix_coin_d;
      eat_q         <= eat_d;
      init_done_q   <= init_done_d;
      level_clear_q <= level_clear_d;
    end
  end

  assign rom_addr    = rom_addr_q;
  assign coins_left  = coins_q;
  assign score       = score_q;
  assign pix_coin    = pix_coin_q;
  assign eat_pulse   = eat_q;
  assign init_done   = init_done_q;
  assign level_clear = level_clear_q;

endmodule

// File: tb/tb_coin_tracker.sv
// ---------------------------------------------------------------------------
// tb_coin_tracker
//
// Self-checking bench for coin_tracker. A behavioural map ROM feeds the
// scan. A small model of the coin map, count and score supplies the
// expected pixel lookups and eat pulses. These go into queues as stimulus
// is driven and are popped one cycle later, when the design answers.
// Inputs change on the falling clock edge and outputs are sampled there.
// ---------------------------------------------------------------------------
module tb_coin_tracker;

  localparam int N       = 1296;
  localparam int ADDR_W  = 11;
  localparam int SCORE_W = 16;
  localparam int LIMIT   = N + 20;

  logic               clk_pix = 1'b0;
  logic               rstn;
  logic               start;
  logic               game_reset;
  logic [ADDR_W-1:0]  rom_addr;
  logic [3:0]         rom_code;
  logic               pac_valid;
  logic [ADDR_W-1:0]  pac_tile_addr;
  logic [ADDR_W-1:0]  pix_tile_addr;
  logic               pix_coin;
  logic [ADDR_W-1:0]  coins_left;
  logic [SCORE_W-1:0] score;
  logic               eat_pulse;
  logic               init_done;
  logic               level_clear;

  int checks = 0;
  int errors = 0;
  int romMode = 0;

  bit modelMap [N];
  int modelCoins = 0;
  int modelScore = 0;
  bit modelRun   = 1'b0;
  bit modelClear = 1'b0;

  bit expPixQ [$];
  bit expEatQ [$];

  coin_tracker dut (
    .clk_pix       (clk_pix),
    .rstn          (rstn),
    .start         (start),
    .game_reset    (game_reset),
    .rom_addr      (rom_addr),
    .rom_code      (rom_code),
    .pac_valid     (pac_valid),
    .pac_tile_addr (pac_tile_addr),
    .pix_tile_addr (pix_tile_addr),
    .pix_coin      (pix_coin),
    .coins_left    (coins_left),
    .score         (score),
    .eat_pulse     (eat_pulse),
    .init_done     (init_done),
    .level_clear   (level_clear)
  );

  always #5 clk_pix = ~clk_pix;

  // Map contents. Mode 0 has coins at tiles 0, 5 and 1295 only, with other
  // non-zero codes scattered around them. Mode 1 has no coin codes at all.
  function automatic logic [3:0] romLookup(int mode, int addr);
    if (mode == 0) begin
      if (addr == 0 || addr == 5 || addr == 1295) return 4'd2;
      if (addr % 7 == 1) return 4'd1;
      if (addr % 7 == 3) return 4'd3;
      return 4'd0;
    end
    if (addr % 5 == 0) return 4'd3;
    return 4'd0;
  endfunction

  // Synchronous map ROM: data follows the address by one clock.
  always @(posedge clk_pix) rom_code <= romLookup(romMode, int'(rom_addr));

  task automatic tick;
    @(posedge clk_pix);
    @(negedge clk_pix);
  endtask

  task automatic modelLoad(input int mode);
    modelCoins = 0;
    for (int i = 0; i < N; i++) begin
      modelMap[i] = (romLookup(mode, i) == 4'd2);
      if (modelMap[i]) modelCoins++;
    end
    modelRun   = (modelCoins > 0);
    modelClear = (modelCoins == 0);
  endtask

  // Drives a pixel lookup and queues the model's answer.
  task automatic applyPix(input int addr);
    bit exp;
    pix_tile_addr = ADDR_W'(addr);
    exp = (modelRun || modelClear) && (addr < N) && modelMap[addr];
    expPixQ.push_back(exp);
  endtask

  // Drives one Pacman tile (optionally with game_reset), queues the
  // expected eat pulse and moves the model forward.
  task automatic applyPac(input int addr, input bit gr);
    bit exp;
    pac_valid     = 1'b1;
    pac_tile_addr = ADDR_W'(addr);
    game_reset    = gr;
    exp = modelRun && !gr && (addr < N) && modelMap[addr];
    expEatQ.push_back(exp);
    if (exp) begin
      modelMap[addr] = 1'b0;
      modelCoins--;
      modelScore = (modelScore + 10 > 65535) ? 65535 : modelScore + 10;
      if (modelCoins == 0) begin
        modelRun   = 1'b0;
        modelClear = 1'b1;
      end
    end
    if (gr) begin
      modelRun   = 1'b0;
      modelClear = 1'b0;
    end
  endtask

  task automatic test_reset;
    logic [41:0] outs;
    #2;
    outs = {rom_addr, coins_left, score, pix_coin, eat_pulse, init_done, level_clear};
    checks++;
    if (outs !== 42'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %h expected 0", outs);
    end
    @(negedge clk_pix);
    rstn = 1'b1;
    tick();
    game_reset = 1'b1;
    tick();
    game_reset = 1'b0;
    repeat (3) tick();
    checks++;
    if (rom_addr !== 11'd0) begin
      errors++;
      $display("[TB] FAIL idle_game_reset_addr: got %0d expected 0", rom_addr);
    end
    checks++;
    if (init_done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_game_reset_init: got %0b expected 0", init_done);
    end
  endtask

  task automatic test_scan;
    int cyc;
    logic [ADDR_W-1:0] a0, a1;
    romMode = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    a0 = rom_addr;
    tick();
    a1 = rom_addr;
    cyc = 2;
    while (init_done !== 1'b1 && cyc < LIMIT) begin
      tick();
      cyc++;
    end
    modelLoad(0);
    checks++;
    if (a0 !== 11'd0 || a1 !== 11'd1) begin
      errors++;
      $display("[TB] FAIL scan_rom_addr: got %0d,%0d expected 0,1", a0, a1);
    end
    checks++;
    if (cyc != N + 2) begin
      errors++;
      $display("[TB] FAIL scan_latency: got %0d cycles expected %0d", cyc, N + 2);
    end
    checks++;
    if (coins_left !== ADDR_W'(modelCoins)) begin
      errors++;
      $display("[TB] FAIL scan_coins_left: got %0d expected %0d", coins_left, modelCoins);
    end
    checks++;
    if (level_clear !== 1'b0) begin
      errors++;
      $display("[TB] FAIL scan_level_clear: got %0b expected 0", level_clear);
    end
    foreach (expPixQ[i]) expPixQ.delete(i);
    for (int k = 0; k < 5; k++) begin
      int probe;
      bit exp;
      case (k)
        0: probe = 5;
        1: probe = 6;
        2: probe = 0;
        3: probe = 1295;
        default: probe = 1300;
      endcase
      applyPix(probe);
      tick();
      exp = expPixQ.pop_front();
      checks++;
      if (pix_coin !== exp) begin
        errors++;
        $display("[TB] FAIL pix_lookup_%0d: got %0b expected %0b", probe, pix_coin, exp);
      end
    end
  endtask

  task automatic test_eat;
    bit exp;
    for (int k = 0; k < 3; k++) begin
      applyPac(5, 1'b0);
      tick();
      exp = expEatQ.pop_front();
      checks++;
      if (eat_pulse !== exp) begin
        errors++;
        $display("[TB] FAIL eat_pulse_cycle%0d: got %0b expected %0b", k, eat_pulse, exp);
      end
      checks++;
      if (coins_left !== ADDR_W'(modelCoins) || score !== SCORE_W'(modelScore)) begin
        errors++;
        $display("[TB] FAIL eat_counts_cycle%0d: got coins %0d score %0d expected coins %0d score %0d",
                 k, coins_left, score, modelCoins, modelScore);
      end
    end
    pac_valid = 1'b0;
    applyPix(5);
    tick();
    exp = expPixQ.pop_front();
    checks++;
    if (pix_coin !== exp) begin
      errors++;
      $display("[TB] FAIL eat_pix_cleared: got %0b expected %0b", pix_coin, exp);
    end
    checks++;
    if (eat_pulse !== 1'b0) begin
      errors++;
      $display("[TB] FAIL eat_pulse_idle: got %0b expected 0", eat_pulse);
    end
  endtask

  task automatic test_level_clear;
    bit exp;
    for (int k = 0; k < 2; k++) begin
      applyPac((k == 0) ? 0 : 1295, 1'b0);
      tick();
      exp = expEatQ.pop_front();
      checks++;
      if (eat_pulse !== exp || level_clear !== modelClear) begin
        errors++;
        $display("[TB] FAIL clear_eat%0d: got eat %0b clear %0b expected eat %0b clear %0b",
                 k, eat_pulse, level_clear, exp, modelClear);
      end
    end
    pac_valid = 1'b0;
    checks++;
    if (coins_left !== ADDR_W'(modelCoins) || score !== SCORE_W'(modelScore)) begin
      errors++;
      $display("[TB] FAIL clear_counts: got coins %0d score %0d expected coins %0d score %0d",
               coins_left, score, modelCoins, modelScore);
    end
    tick();
    checks++;
    if (level_clear !== 1'b1 || init_done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL clear_hold: got clear %0b init %0b expected 1 1", level_clear, init_done);
    end
  endtask

  task automatic test_rescan;
    int cyc;
    int bad;
    game_reset = 1'b1;
    modelRun   = 1'b0;
    modelClear = 1'b0;
    tick();
    game_reset = 1'b0;
    pix_tile_addr = 11'd5;
    cyc = 1;
    bad = 0;
    while (init_done !== 1'b1 && cyc < LIMIT) begin
      if (pix_coin !== 1'b0) bad++;
      tick();
      cyc++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("[TB] FAIL rescan_pix_masked: got %0d cycles with pix_coin set expected 0", bad);
    end
    modelLoad(0);
    checks++;
    if (cyc != N + 2) begin
      errors++;
      $display("[TB] FAIL rescan_latency: got %0d cycles expected %0d", cyc, N + 2);
    end
    checks++;
    if (coins_left !== ADDR_W'(modelCoins) || score !== SCORE_W'(modelScore) || level_clear !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rescan_counts: got coins %0d score %0d clear %0b expected coins %0d score %0d clear 0",
               coins_left, score, level_clear, modelCoins, modelScore);
    end
  endtask

  task automatic test_back_to_back;
    int cyc;
    bit exp;
    applyPac(5, 1'b1);
    tick();
    pac_valid  = 1'b0;
    game_reset = 1'b0;
    exp = expEatQ.pop_front();
    checks++;
    if (eat_pulse !== exp || score !== SCORE_W'(modelScore)) begin
      errors++;
      $display("[TB] FAIL collide_eat_dropped: got eat %0b score %0d expected eat %0b score %0d",
               eat_pulse, score, exp, modelScore);
    end
    cyc = 1;
    while (init_done !== 1'b1 && cyc < LIMIT) begin
      tick();
      cyc++;
    end
    modelLoad(0);
    checks++;
    if (cyc != N + 2 || coins_left !== ADDR_W'(modelCoins)) begin
      errors++;
      $display("[TB] FAIL collide_rescan: got %0d cycles coins %0d expected %0d cycles coins %0d",
               cyc, coins_left, N + 2, modelCoins);
    end
    applyPix(5);
    tick();
    exp = expPixQ.pop_front();
    checks++;
    if (pix_coin !== exp) begin
      errors++;
      $display("[TB] FAIL collide_coin_kept: got %0b expected %0b", pix_coin, exp);
    end
  endtask

  task automatic test_no_coins;
    int cyc;
    bit exp;
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    modelScore = 0;
    romMode = 1;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    while (init_done !== 1'b1 && cyc < LIMIT) begin
      tick();
      cyc++;
    end
    modelLoad(1);
    checks++;
    if (cyc != N + 2 || level_clear !== modelClear || coins_left !== ADDR_W'(modelCoins)) begin
      errors++;
      $display("[TB] FAIL empty_scan: got %0d cycles clear %0b coins %0d expected %0d cycles clear %0b coins %0d",
               cyc, level_clear, coins_left, N + 2, modelClear, modelCoins);
    end
    applyPac(1300, 1'b0);
    tick();
    pac_valid = 1'b0;
    exp = expEatQ.pop_front();
    checks++;
    if (eat_pulse !== exp || score !== SCORE_W'(modelScore) || coins_left !== ADDR_W'(modelCoins)) begin
      errors++;
      $display("[TB] FAIL out_of_range_pac: got eat %0b score %0d coins %0d expected eat %0b score %0d coins %0d",
               eat_pulse, score, coins_left, exp, modelScore, modelCoins);
    end
    applyPix(1300);
    tick();
    exp = expPixQ.pop_front();
    checks++;
    if (pix_coin !== exp) begin
      errors++;
      $display("[TB] FAIL out_of_range_pix: got %0b expected %0b", pix_coin, exp);
    end
  endtask

  task automatic test_async_reset;
    logic [41:0] outs;
    romMode = 0;
    game_reset = 1'b1;
    tick();
    game_reset = 1'b0;
    repeat (100) tick();
    #2;
    rstn = 1'b0;
    #1;
    outs = {rom_addr, coins_left, score, pix_coin, eat_pulse, init_done, level_clear};
    checks++;
    if (outs !== 42'd0) begin
      errors++;
      $display("[TB] FAIL async_reset_mid_scan: got %h expected 0", outs);
    end
    @(negedge clk_pix);
    rstn = 1'b1;
    tick();
  endtask

  initial begin
    rstn          = 1'b0;
    start         = 1'b0;
    game_reset    = 1'b0;
    pac_valid     = 1'b0;
    pac_tile_addr = '0;
    pix_tile_addr = '0;
    $display("[TB] coin_tracker bench starting");
    test_reset();
    test_scan();
    test_eat();
    test_level_clear();
    test_rescan();
    test_back_to_back();
    test_no_coins();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
